axi_mem_slave: RTL and testbench

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

---
 rtl/axi_mem_slave.sv | 247 ++++++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_slave.sv
// AXI4 burst memory slave: independent write and read FSMs over a word-addressed array preloaded with its index.
// Optional AXI_MEM_SLAVE_DECERR_EN: beats whose unwrapped word index is past MEM_DEPTH get DECERR instead of wrapping.
module axi_mem_slave #(
    parameter int ADDR_WD   = 32,
    parameter int DATA_WD   = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 S_AXI_AWVALID,
    output logic                 S_AXI_AWREADY,
    input  logic [ADDR_WD-1:0]   S_AXI_AWADDR,
    input  logic [7:0]           S_AXI_AWLEN,
    input  logic [1:0]           S_AXI_AWBURST,
    input  logic                 S_AXI_WVALID,
    output logic                 S_AXI_WREADY,
    input  logic [DATA_WD-1:0]   S_AXI_WDATA,
    input  logic [DATA_WD/8-1:0] S_AXI_WSTRB,
    input  logic                 S_AXI_WLAST,
    output logic                 S_AXI_BVALID,
    input  logic                 S_AXI_BREADY,
    output logic [1:0]           S_AXI_BRESP,
    input  logic                 S_AXI_ARVALID,
    output logic                 S_AXI_ARREADY,
    input  logic [ADDR_WD-1:0]   S_AXI_ARADDR,
    input  logic [7:0]           S_AXI_ARLEN,
    input  logic [1:0]           S_AXI_ARBURST,
    output logic                 S_AXI_RVALID,
    input  logic                 S_AXI_RREADY,
    output logic [DATA_WD-1:0]   S_AXI_RDATA,
    output logic [1:0]           S_AXI_RRESP,
    output logic                 S_AXI_RLAST
);
    localparam int STRB_WD = DATA_WD / 8;
    localparam int BSHIFT  = $clog2(STRB_WD);
    localparam int IDX_WD  = $clog2(MEM_DEPTH);
`ifdef AXI_MEM_SLAVE_DECERR_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif
    localparam logic [ADDR_WD-1:0] DEPTH_A = ADDR_WD'(MEM_DEPTH);
    localparam logic [ADDR_WD-1:0] ONE_A   = ADDR_WD'(1);
    localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic [1:0] eff_burst(input logic [1:0] burst, input logic [7:0] len);
        logic [1:0] mode;
        mode = BURST_INCR;
        if (burst == BURST_FIXED) mode = BURST_FIXED;
        else if (burst == BURST_WRAP && wrap_len_ok(len)) mode = BURST_WRAP;
        return mode;
    endfunction

    function automatic logic bad_burst(input logic [1:0] burst, input logic [7:0] len);
        return (burst == 2'b11) || (burst == BURST_WRAP && !wrap_len_ok(len));
    endfunction

    // WRAP windows are len+1 words (a power of two), so len doubles as the in-window mask.
    function automatic logic [ADDR_WD-1:0] next_word(input logic [ADDR_WD-1:0] a,
                                                     input logic [7:0] len, input logic [1:0] mode);
        logic [ADDR_WD-1:0] mask;
        logic [ADDR_WD-1:0] nxt;
        mask = ADDR_WD'(len);
        case (mode)
            BURST_FIXED: nxt = a;
            BURST_WRAP:  nxt = (a & ~mask) | ((a + ONE_A) & mask);
            default:     nxt = a + ONE_A;
        endcase
        return nxt;
    endfunction

    function automatic logic out_of_range(input logic [ADDR_WD-1:0] a);
        return DEC_EN && (a >= DEPTH_A);
    endfunction

    logic                 r_alive;
    logic [DATA_WD-1:0]   r_mem [MEM_DEPTH];

    wstate_t              r_wstate, w_wstate_next;
    logic [ADDR_WD-1:0]   r_waddr;
    logic [7:0]           r_wlen, r_wcnt;
    logic [1:0]           r_wmode, r_bresp;
    logic                 r_wslv, r_wdec;
    logic                 w_aw_hs, w_w_hs, w_w_last_beat, w_woor, w_b_dec, w_b_slv;
    logic [ADDR_WD-1:0]   w_aw_word;

    rstate_t              r_rstate, w_rstate_next;
    logic [ADDR_WD-1:0]   r_raddr;
    logic [7:0]           r_rlen, r_rcnt;
    logic [1:0]           r_rmode, r_rresp;
    logic                 r_rslv, r_rlast;
    logic [DATA_WD-1:0]   r_rdata;
    logic                 w_ar_hs, w_r_hs, w_rd_load, w_rd_oor, w_rd_slv;
    logic [ADDR_WD-1:0]   w_ar_word, w_rd_word;

    // Holds both READY outputs low through reset and releases them on the first clock after it.
    always_ff @(posedge clk) begin
        if (rst) r_alive <= 1'b0;
        else     r_alive <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_next;
            r_rstate <= w_rstate_next;
        end
    end

    always_comb begin
        w_wstate_next = r_wstate;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                S_AXI_AWREADY = r_alive;
                if (S_AXI_AWVALID && r_alive) w_wstate_next = W_DATA;
            end
            W_DATA: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID && w_w_last_beat) w_wstate_next = W_RESP;
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) w_wstate_next = W_IDLE;
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_next = r_rstate;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                S_AXI_ARREADY = r_alive;
                if (S_AXI_ARVALID && r_alive) w_rstate_next = R_DATA;
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY && r_rlast) w_rstate_next = R_IDLE;
            end
            default: w_rstate_next = R_IDLE;
        endcase
    end

    assign w_aw_hs       = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_w_hs        = S_AXI_WVALID & S_AXI_WREADY;
    assign w_aw_word     = S_AXI_AWADDR >> BSHIFT;
    assign w_w_last_beat = (r_wcnt == r_wlen);
    assign w_woor        = out_of_range(r_waddr);
    assign w_b_dec       = r_wdec | w_woor;
    assign w_b_slv       = r_wslv | (S_AXI_WLAST != w_w_last_beat);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_waddr <= '0;
            r_wlen  <= '0;
            r_wcnt  <= '0;
            r_wmode <= BURST_INCR;
            r_wslv  <= 1'b0;
            r_wdec  <= 1'b0;
            r_bresp <= RESP_OKAY;
        end else if (w_aw_hs) begin
            r_waddr <= w_aw_word;
            r_wlen  <= S_AXI_AWLEN;
            r_wcnt  <= '0;
            r_wmode <= eff_burst(S_AXI_AWBURST, S_AXI_AWLEN);
            r_wslv  <= bad_burst(S_AXI_AWBURST, S_AXI_AWLEN);
            r_wdec  <= 1'b0;
        end else if (w_w_hs) begin
            r_waddr <= next_word(r_waddr, r_wlen, r_wmode);
            r_wcnt  <= r_wcnt + 8'd1;
            r_wslv  <= w_b_slv;
            r_wdec  <= w_b_dec;
            if (w_w_last_beat)
                r_bresp <= w_b_dec ? RESP_DECERR : (w_b_slv ? RESP_SLVERR : RESP_OKAY);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= DATA_WD'(i);
        end else if (w_w_hs && !w_woor) begin
            for (int b = 0; b < STRB_WD; b++)
                if (S_AXI_WSTRB[b]) r_mem[r_waddr[IDX_WD-1:0]][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
        end
    end

    // One shared read port: the AR handshake fetches beat 0, each later R handshake prefetches the next beat.
    assign w_ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
    assign w_r_hs    = S_AXI_RVALID & S_AXI_RREADY;
    assign w_ar_word = S_AXI_ARADDR >> BSHIFT;
    assign w_rd_word = w_ar_hs ? w_ar_word : r_raddr;
    assign w_rd_oor  = out_of_range(w_rd_word);
    assign w_rd_slv  = w_ar_hs ? bad_burst(S_AXI_ARBURST, S_AXI_ARLEN) : r_rslv;
    assign w_rd_load = w_ar_hs | (w_r_hs & ~r_rlast);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_rresp <= RESP_OKAY;
            r_rlast <= 1'b0;
            r_raddr <= '0;
            r_rlen  <= '0;
            r_rcnt  <= '0;
            r_rmode <= BURST_INCR;
            r_rslv  <= 1'b0;
        end else begin
            if (w_rd_load) begin
                r_rdata <= w_rd_oor ? '0 : r_mem[w_rd_word[IDX_WD-1:0]];
                r_rresp <= w_rd_oor ? RESP_DECERR : (w_rd_slv ? RESP_SLVERR : RESP_OKAY);
            end
            if (w_ar_hs) begin
                r_raddr <= next_word(w_ar_word, S_AXI_ARLEN, eff_burst(S_AXI_ARBURST, S_AXI_ARLEN));
                r_rlen  <= S_AXI_ARLEN;
                r_rcnt  <= '0;
                r_rmode <= eff_burst(S_AXI_ARBURST, S_AXI_ARLEN);
                r_rslv  <= bad_burst(S_AXI_ARBURST, S_AXI_ARLEN);
                r_rlast <= (S_AXI_ARLEN == 8'd0);
            end else if (w_r_hs && !r_rlast) begin
                r_raddr <= next_word(r_raddr, r_rlen, r_rmode);
                r_rcnt  <= r_rcnt + 8'd1;
                r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
            end else if (w_r_hs) begin
                r_rlast <= 1'b0;
            end
        end
    end

    assign S_AXI_BRESP = r_bresp;
    assign S_AXI_RDATA = r_rdata;
    assign S_AXI_RRESP = r_rresp;
    assign S_AXI_RLAST = r_rlast;
endmodule

// File: tb/tb_axi_mem_slave.sv
// Bench for axi_mem_slave (DATA_WD=32, MEM_DEPTH=1024): directed bursts then random ones against a word-array model.
module tb_axi_mem_slave;
    localparam int DEPTH = 1024;
`ifdef AXI_MEM_SLAVE_DECERR_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        S_AXI_AWVALID, S_AXI_AWREADY;
    logic [31:0] S_AXI_AWADDR;
    logic [7:0]  S_AXI_AWLEN;
    logic [1:0]  S_AXI_AWBURST;
    logic        S_AXI_WVALID, S_AXI_WREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WLAST;
    logic        S_AXI_BVALID, S_AXI_BREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_ARVALID, S_AXI_ARREADY;
    logic [31:0] S_AXI_ARADDR;
    logic [7:0]  S_AXI_ARLEN;
    logic [1:0]  S_AXI_ARBURST;
    logic        S_AXI_RVALID, S_AXI_RREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;

    axi_mem_slave #(.ADDR_WD(32), .DATA_WD(32), .MEM_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_AWADDR(S_AXI_AWADDR),
        .S_AXI_AWLEN(S_AXI_AWLEN), .S_AXI_AWBURST(S_AXI_AWBURST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_WDATA(S_AXI_WDATA),
        .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
        .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARBURST(S_AXI_ARBURST),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .S_AXI_RDATA(S_AXI_RDATA),
        .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] mmem [DEPTH];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    logic [31:0] rd_data [$];
    logic [1:0]  rd_resp [$];
    logic        rd_last [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit wrap_ok(input int len);
        return (len == 1) || (len == 3) || (len == 7) || (len == 15);
    endfunction

    // Unwrapped word index of beat k, straight from the burst-type rules.
    function automatic int beat_idx(input int start, input int len, input int burst, input int k);
        int base;
        if (burst == 0) return start;
        if (burst == 2 && wrap_ok(len)) begin
            base = start - (start % (len + 1));
            return base + ((start - base + k) % (len + 1));
        end
        return start + k;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mmem[i] = i;
    endtask

    task automatic model_write(input int addr, input int len, input int burst, input int lastpos,
                               output logic [1:0] resp);
        bit dec, slv;
        int idx;
        dec = 0;
        slv = (burst == 3) || (burst == 2 && !wrap_ok(len)) || (lastpos != len);
        for (int k = 0; k <= len; k++) begin
            idx = beat_idx(addr / 4, len, burst, k);
            if (DEC && idx >= DEPTH) dec = 1;
            else
                for (int b = 0; b < 4; b++)
                    if (ws[k][b]) mmem[idx % DEPTH][b*8 +: 8] = wd[k][b*8 +: 8];
        end
        resp = dec ? 2'b11 : (slv ? 2'b10 : 2'b00);
    endtask

    task automatic model_read(input int addr, input int len, input int burst, input int k,
                              output logic [31:0] d, output logic [1:0] r);
        int idx;
        idx = beat_idx(addr / 4, len, burst, k);
        if (DEC && idx >= DEPTH) begin
            d = 0;
            r = 2'b11;
        end else begin
            d = mmem[idx % DEPTH];
            r = (burst == 3 || (burst == 2 && !wrap_ok(len))) ? 2'b10 : 2'b00;
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input int len, input int burst, input int lastpos,
                             output logic [1:0] bresp);
        int n;
        @(negedge clk);
        S_AXI_AWADDR = addr; S_AXI_AWLEN = 8'(len); S_AXI_AWBURST = 2'(burst); S_AXI_AWVALID = 1'b1;
        n = 0;
        while (!S_AXI_AWREADY && n < 100) begin @(negedge clk); n++; end
        chk("aw_wait", n < 100, 1);
        @(negedge clk);
        S_AXI_AWVALID = 1'b0;
        for (int k = 0; k <= len; k++) begin
            S_AXI_WDATA = wd[k]; S_AXI_WSTRB = ws[k]; S_AXI_WLAST = (k == lastpos); S_AXI_WVALID = 1'b1;
            n = 0;
            while (!S_AXI_WREADY && n < 100) begin @(negedge clk); n++; end
            if (n >= 100) chk("w_wait", 0, 1);
            @(negedge clk);
        end
        S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
        S_AXI_BREADY = 1'b1;
        n = 0;
        while (!S_AXI_BVALID && n < 100) begin @(negedge clk); n++; end
        chk("b_wait", n < 100, 1);
        bresp = S_AXI_BRESP;
        @(negedge clk);
        S_AXI_BREADY = 1'b0;
        chk("b_done_awready", S_AXI_AWREADY, 1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int len, input int burst, input bit toggle);
        int n, beats, cyc;
        bit stalled;
        logic [34:0] held;
        rd_data.delete(); rd_resp.delete(); rd_last.delete();
        @(negedge clk);
        S_AXI_ARADDR = addr; S_AXI_ARLEN = 8'(len); S_AXI_ARBURST = 2'(burst); S_AXI_ARVALID = 1'b1;
        n = 0;
        while (!S_AXI_ARREADY && n < 100) begin @(negedge clk); n++; end
        chk("ar_wait", n < 100, 1);
        @(negedge clk);
        S_AXI_ARVALID = 1'b0;
        chk("r_first_latency", S_AXI_RVALID, 1);
        beats = 0; cyc = 0; stalled = 0; held = '0;
        while (beats < len + 1 && cyc < 600) begin
            if (stalled) chk("r_stall_hold", {S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST}, {1'b1, held});
            S_AXI_RREADY = toggle ? (cyc % 2 == 1) : 1'b1;
            stalled = 0;
            if (S_AXI_RVALID) begin
                if (S_AXI_RREADY) begin
                    rd_data.push_back(S_AXI_RDATA); rd_resp.push_back(S_AXI_RRESP); rd_last.push_back(S_AXI_RLAST);
                    beats++;
                end else begin
                    stalled = 1;
                    held = {S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST};
                end
            end
            @(negedge clk);
            cyc++;
        end
        S_AXI_RREADY = 1'b0;
        chk("r_beat_count", beats, len + 1);
        if (!toggle) chk("r_back_to_back", cyc, len + 1);
        chk("r_done_rvalid", S_AXI_RVALID, 0);
        chk("r_done_arready", S_AXI_ARREADY, 1);
    endtask

    task automatic check_read(input logic [31:0] addr, input int len, input int burst);
        logic [31:0] d;
        logic [1:0]  r;
        for (int k = 0; k < rd_data.size(); k++) begin
            model_read(addr, len, burst, k, d, r);
            chk("rd_data", rd_data[k], d);
            chk("rd_resp", rd_resp[k], r);
            chk("rd_last", rd_last[k], k == len);
        end
    endtask

    initial begin
        logic [1:0] br, exp_br;
        int addr, len, burst, lastpos;
        bit toggle;
        rst = 1'b1;
        S_AXI_AWVALID = 0; S_AXI_AWADDR = 0; S_AXI_AWLEN = 0; S_AXI_AWBURST = 0;
        S_AXI_WVALID = 0; S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WLAST = 0; S_AXI_BREADY = 0;
        S_AXI_ARVALID = 0; S_AXI_ARADDR = 0; S_AXI_ARLEN = 0; S_AXI_ARBURST = 0; S_AXI_RREADY = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_ready", {S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY}, 0);
        chk("rst_valid", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_RLAST}, 0);
        chk("rst_resp", {S_AXI_BRESP, S_AXI_RRESP}, 0);
        chk("rst_rdata", S_AXI_RDATA, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {S_AXI_AWREADY, S_AXI_ARREADY}, 2'b11);

        axi_read(32'h10, 3, 1, 0);
        for (int k = 0; k < rd_data.size(); k++) begin
            chk("incr_data", rd_data[k], 4 + k);
            chk("incr_resp", rd_resp[k], 0);
            chk("incr_last", rd_last[k], k == 3);
        end

        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF; wd[1] = 32'h12345678; ws[1] = 4'h3;
        axi_write(32'h40, 1, 1, 1, br);
        model_write(32'h40, 1, 1, 1, exp_br);
        chk("strb_bresp", br, 2'b00);
        axi_read(32'h40, 1, 1, 0);
        if (rd_data.size() == 2) begin
            chk("strb_beat0", rd_data[0], 32'hDEADBEEF);
            chk("strb_beat1", rd_data[1], 32'h00005678);
        end

        axi_read(32'h18, 3, 2, 0);
        if (rd_data.size() == 4) begin
            chk("wrap_b0", rd_data[0], 6); chk("wrap_b1", rd_data[1], 7);
            chk("wrap_b2", rd_data[2], 4); chk("wrap_b3", rd_data[3], 5);
        end
        for (int k = 0; k < 3; k++) begin wd[k] = k + 1; ws[k] = 4'hF; end
        axi_write(32'h8, 2, 0, 2, br);
        model_write(32'h8, 2, 0, 2, exp_br);
        chk("fixed_bresp", br, 2'b00);
        axi_read(32'h8, 0, 1, 0);
        if (rd_data.size() == 1) chk("fixed_word2", rd_data[0], 3);

        for (int k = 0; k < 3; k++) begin wd[k] = 32'hA500_0000 + k; ws[k] = 4'hF; end
        axi_write(32'h100, 2, 1, 1, br);
        model_write(32'h100, 2, 1, 1, exp_br);
        chk("wlast_early_bresp", br, 2'b10);
        axi_read(32'h100, 3, 1, 1);
        check_read(32'h100, 3, 1);

        axi_read(32'hFFC, 1, 1, 0);
        if (rd_data.size() == 2) begin
            chk("edge_b0_data", rd_data[0], 1023);
            chk("edge_b0_resp", rd_resp[0], 0);
            chk("edge_b1_data", rd_data[1], 0);
            chk("edge_b1_resp", rd_resp[1], DEC ? 2'b11 : 2'b00);
        end

        for (int t = 0; t < 30; t++) begin
            addr = $urandom_range(0, 32'hFFF);
            len = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                burst = $urandom_range(0, 3);
                lastpos = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : len;
                for (int k = 0; k <= len; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom_range(0, 15)); end
                model_write(addr, len, burst, lastpos, exp_br);
                axi_write(addr, len, burst, lastpos, br);
                chk("rand_bresp", br, exp_br);
            end else begin
                burst = $urandom_range(0, 2);
                if (burst == 2) len = (2 << $urandom_range(0, 2)) - 1;
                toggle = 1'($urandom_range(0, 1));
                axi_read(addr, len, burst, toggle);
                check_read(addr, len, burst);
            end
        end

        @(negedge clk);
        S_AXI_ARADDR = 32'h0; S_AXI_ARLEN = 8'd7; S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1'b1;
        @(negedge clk);
        S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1; S_AXI_RREADY = 1'b0;
        @(negedge clk);
        chk("midrst_quiet", {S_AXI_RVALID, S_AXI_RLAST, S_AXI_ARREADY, S_AXI_BVALID}, 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midrst_arready", S_AXI_ARREADY, 1);
        axi_read(32'h40, 0, 1, 0);
        if (rd_data.size() == 1) chk("midrst_preload", rd_data[0], 32'h10);
        check_read(32'h40, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
